debug_program_ctrl: RTL and testbench
=====================================

Name: debug_program_ctrl

Overview:
- Debug-side sequencer for the fetch stage.
- Parses a byte command stream from the debug UART receiver and loads programs into instruction memory through the fetch stage's debug write port.
- Issues single-step pulses, or continuous-run steps, to the pipeline.
- Stops continuous run when the fetched instruction equals a halt opcode.

Parameters:
- NB, 32, datapath/instruction width.
- TAM_I, 256, instruction memory size in bytes; capacity is TAM_I/4 words.
- CMD_LOAD, 8'h4C, load-program command byte.
- CMD_STEP, 8'h53, single-step command byte.
- CMD_RUN, 8'h43, continuous-run command byte.
- HALT_INSTR, 32'hFFFFFFFF, instruction that terminates continuous run.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_reset  in  1  synchronous reset, active-low (0 = reset).
- i_rx_data  in  8  received byte.
- i_rx_valid  in  1  one-cycle strobe; i_rx_data is valid this cycle.
- i_IF_instruction  in  NB  instruction currently fetched by the fetch stage.
- o_instruction_write_enable  out  1  one-cycle instruction-memory write strobe.
- o_instruction_address  out  NB  byte address of the write (word index × 4).
- o_instruction_data  out  NB  assembled instruction word.
- o_step  out  1  pipeline advance enable.
- o_running  out  1  high while in RUN.
- o_load_done  out  1  one-cycle pulse after the last word of a program is written.
- o_error  out  1  one-cycle pulse on a protocol error.
- o_program_loaded  out  1  sticky; set by a successful load.

Behaviour:
- All outputs are registered.
- Reset (i_reset = 0 at a clock edge): state=IDLE; every output = 0; word index, byte count and word count = 0.
- Reset applied mid-load or mid-run aborts immediately.
- States: IDLE, LOAD_CNT, LOAD_BYTE, WRITE, STEP, RUN.
- IDLE, on i_rx_valid:
  - CMD_LOAD -> LOAD_CNT.
  - CMD_STEP -> STEP if o_program_loaded, else o_error pulse and stay in IDLE.
  - CMD_RUN -> RUN if o_program_loaded, else o_error pulse and stay in IDLE.
  - Any other byte -> o_error pulse, stay in IDLE.
- LOAD_CNT: next valid byte N is the word count.
  - N = 0 or N > TAM_I/4 -> o_error pulse, go to IDLE; o_program_loaded unchanged.
  - Otherwise store N, clear word index and byte count, clear o_program_loaded, go to LOAD_BYTE.
- LOAD_BYTE: bytes arrive little-endian. Byte k (0..3) fills bits [8k+7:8k] of the assembly register. On the 4th byte -> WRITE.
- WRITE: lasts one cycle.
  - o_instruction_write_enable = 1; o_instruction_address = index × 4 (zero-extended to NB); o_instruction_data = assembled word.
  - Increment index. If index+1 == N: pulse o_load_done, set o_program_loaded, go to IDLE. Otherwise go to LOAD_BYTE.
  - An i_rx_valid arriving during WRITE is captured as byte 0 of the next word; no byte is lost.
- STEP: o_step = 1 for exactly one cycle, then IDLE.
- RUN: o_step = 1 and o_running = 1 every cycle.
  - If i_IF_instruction == HALT_INSTR during RUN, the next edge drives o_step = 0, o_running = 0, state = IDLE.
  - A halt match on the first RUN cycle also stops.
  - Bytes received during RUN are ignored; no error.
- Latency: a command byte accepted at edge t produces its first output effect (o_step, or a state change) at edge t+1.
- o_error and o_load_done never assert in the same cycle.
- A new load overwrites memory from address 0. Words beyond the new N keep their old contents.

Test Plan:
- Reset, then load: release i_reset; send 4C,02, then 78,56,34,12, then 21,43,65,87 -> write pulses at address 0 with data 0x12345678 and at address 4 with data 0x87654321; o_load_done pulses once; o_program_loaded=1.
- Guard and bad command: from reset send 53 -> o_error pulse, o_step stays 0. Send 7A -> o_error pulse.
- Bad word counts: send 4C,00 -> o_error pulse. Send 4C,41 (65 > 64) -> o_error pulse. State returns to IDLE and no write occurs.
- Single step: after a load, send 53 -> o_step high for exactly 1 cycle, one edge after the strobe.
- Run and halt: send 43 -> o_step stays high; drive i_IF_instruction=0xFFFFFFFF for one cycle -> next cycle o_step=0 and o_running=0. A byte 53 sent during RUN produces no error.
- Reset mid-load: send 4C,03,AA,BB, then pull i_reset low for 1 cycle -> all outputs 0, no write occurs; a subsequent complete load succeeds.

Source files
------------

// File: rtl/debug_program_ctrl_if.sv
// rtl/debug_program_ctrl_if.sv - debug UART byte stream, fetch-stage instruction and imem write port bundle
interface debug_program_ctrl_if #(
  parameter int NB = 32
);
  logic [7:0]    i_rx_data;
  logic          i_rx_valid;
  logic [NB-1:0] i_IF_instruction;
  logic          o_instruction_write_enable;
  logic [NB-1:0] o_instruction_address;
  logic [NB-1:0] o_instruction_data;
  logic          o_step;
  logic          o_running;
  logic          o_load_done;
  logic          o_error;
  logic          o_program_loaded;

  // Side that feeds bytes and the fetched instruction and observes the sequencer.
  modport master (
    output i_rx_data, i_rx_valid, i_IF_instruction,
    input  o_instruction_write_enable, o_instruction_address, o_instruction_data,
    input  o_step, o_running, o_load_done, o_error, o_program_loaded
  );

  // Sequencer side.
  modport slave (
    input  i_rx_data, i_rx_valid, i_IF_instruction,
    output o_instruction_write_enable, o_instruction_address, o_instruction_data,
    output o_step, o_running, o_load_done, o_error, o_program_loaded
  );
endinterface

// File: rtl/debug_program_ctrl.sv
// rtl/debug_program_ctrl.sv - debug command parser, program loader and step/run sequencer
module debug_program_ctrl #(
  parameter int          NB         = 32,
  parameter int          TAM_I      = 256,
  parameter logic [7:0]  CMD_LOAD   = 8'h4C,
  parameter logic [7:0]  CMD_STEP   = 8'h53,
  parameter logic [7:0]  CMD_RUN    = 8'h43,
  parameter logic [31:0] HALT_INSTR = 32'hFFFFFFFF
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  debug_program_ctrl_if.slave   bus
);

  localparam int WORDS = TAM_I / 4;
  // One extra bit so a word count equal to full capacity fits.
  localparam int CNT_W = $clog2(WORDS) + 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD_CNT  = 3'd1;
  localparam logic [2:0] S_LOAD_BYTE = 3'd2;
  localparam logic [2:0] S_WRITE     = 3'd3;
  localparam logic [2:0] S_STEP      = 3'd4;
  localparam logic [2:0] S_RUN       = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [1:0]       byte_q, byte_d;
  logic [NB-1:0]    asm_q, asm_d;
  logic             we_q, we_d;
  logic [NB-1:0]    addr_q, addr_d;
  logic [NB-1:0]    data_q, data_d;
  logic             step_q, step_d;
  logic             running_q, running_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             loaded_q, loaded_d;

  // Next-state and registered-output decode; outputs take effect on the same edge as the state change.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    byte_d    = byte_q;
    asm_d     = asm_q;
    we_d      = 1'b0;
    addr_d    = '0;
    data_d    = '0;
    step_d    = 1'b0;
    running_d = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    loaded_d  = loaded_q;

    case (state_q)
      S_IDLE: begin
        if (bus.i_rx_valid) begin
          if (bus.i_rx_data == CMD_LOAD) begin
            state_d = S_LOAD_CNT;
          end else if (bus.i_rx_data == CMD_STEP && loaded_q) begin
            state_d = S_STEP;
            step_d  = 1'b1;
          end else if (bus.i_rx_data == CMD_RUN && loaded_q) begin
            state_d   = S_RUN;
            step_d    = 1'b1;
            running_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_LOAD_CNT: begin
        if (bus.i_rx_valid) begin
          if (bus.i_rx_data == 8'h00 || int'(bus.i_rx_data) > WORDS) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d    = CNT_W'(bus.i_rx_data);
            idx_d    = '0;
            byte_d   = '0;
            loaded_d = 1'b0;
            state_d  = S_LOAD_BYTE;
          end
        end
      end

      S_LOAD_BYTE: begin
        if (bus.i_rx_valid) begin
          asm_d[{byte_q, 3'b000} +: 8] = bus.i_rx_data;
          byte_d = byte_q + 2'd1;
          if (byte_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = NB'({idx_q, 2'b00});
            data_d  = asm_d;
            state_d = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        idx_d  = idx_q + 1'b1;
        byte_d = '0;
        if (idx_q + 1'b1 == cnt_q) begin
          done_d   = 1'b1;
          loaded_d = 1'b1;
          state_d  = S_IDLE;
        end else begin
          state_d = S_LOAD_BYTE;
          // A byte landing during the write cycle starts the next word.
          if (bus.i_rx_valid) begin
            asm_d[7:0] = bus.i_rx_data;
            byte_d     = 2'd1;
          end
        end
      end

      S_STEP: begin
        state_d = S_IDLE;
      end

      S_RUN: begin
        // Received bytes are deliberately ignored while running.
        if (bus.i_IF_instruction == NB'(HALT_INSTR)) begin
          state_d = S_IDLE;
        end else begin
          step_d    = 1'b1;
          running_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      byte_q    <= '0;
      asm_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      step_q    <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      loaded_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      byte_q    <= byte_d;
      asm_q     <= asm_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      step_q    <= step_d;
      running_q <= running_d;
      done_q    <= done_d;
      err_q     <= err_d;
      loaded_q  <= loaded_d;
    end
  end

  assign bus.o_instruction_write_enable = we_q;
  assign bus.o_instruction_address      = addr_q;
  assign bus.o_instruction_data         = data_q;
  assign bus.o_step                     = step_q;
  assign bus.o_running                  = running_q;
  assign bus.o_load_done                = done_q;
  assign bus.o_error                    = err_q;
  assign bus.o_program_loaded           = loaded_q;

endmodule

// File: tb/tb_debug_program_ctrl.sv
// tb/tb_debug_program_ctrl.sv - directed table-driven bench for debug_program_ctrl
module tb_debug_program_ctrl;

  typedef struct {
    string       name;
    logic        rst_n;
    logic        v;
    logic [7:0]  d;
    logic [31:0] instr;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic        step;
    logic        run;
    logic        done;
    logic        err;
    logic        ld;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  vec_t tbl[$];

  debug_program_ctrl_if #(.NB(32)) bus ();

  debug_program_ctrl dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(string n, logic r, logic v, logic [7:0] d, logic [31:0] ins,
                              logic we, logic [31:0] a, logic [31:0] dat,
                              logic st, logic rn, logic dn, logic er, logic ld);
    vec_t x;
    x.name = n; x.rst_n = r; x.v = v; x.d = d; x.instr = ins;
    x.we = we; x.addr = a; x.data = dat; x.step = st; x.run = rn;
    x.done = dn; x.err = er; x.ld = ld;
    return x;
  endfunction

  task automatic apply(input vec_t x);
    logic [70:0] act, exp;
    rst_n = x.rst_n;
    bus.i_rx_valid = x.v;
    bus.i_rx_data = x.d;
    bus.i_IF_instruction = x.instr;
    @(posedge clk);
    #1;
    act = {bus.o_instruction_write_enable, bus.o_instruction_address, bus.o_instruction_data,
           bus.o_step, bus.o_running, bus.o_load_done, bus.o_error, bus.o_program_loaded};
    exp = {x.we, x.addr, x.data, x.step, x.run, x.done, x.err, x.ld};
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got we=%b addr=%h data=%h step=%b run=%b done=%b err=%b ld=%b, expected we=%b addr=%h data=%h step=%b run=%b done=%b err=%b ld=%b",
               x.name, act[70], act[69:38], act[37:6], act[4], act[3], act[2], act[1], act[0],
               x.we, x.addr, x.data, x.step, x.run, x.done, x.err, x.ld);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.i_rx_valid = 1'b0;
    bus.i_rx_data = 8'h00;
    bus.i_IF_instruction = 32'h0;

    //             name          rst v  data   instr         we addr   data          st rn dn er ld
    tbl.push_back(mk("reset",     0, 0, 8'h00, 32'h0,        0, 32'h0, 32'h0,        0, 0, 0, 0, 0));
    tbl.push_back(mk("idle",      1, 0, 8'h00, 32'h0,        0, 32'h0, 32'h0,        0, 0, 0, 0, 0));
    tbl.push_back(mk("step_nold", 1, 1, 8'h53, 32'h0,        0, 32'h0, 32'h0,        0, 0, 0, 1, 0));
    tbl.push_back(mk("err_clr",   1, 0, 8'h00, 32'h0,        0, 32'h0, 32'h0,        0, 0, 0, 0, 0));
    tbl.push_back(mk("bad_cmd",   1, 1, 8'h7A, 32'h0,        0, 32'h0, 32'h0,        0, 0, 0, 1, 0));
    tbl.push_back(mk("load_a",    1, 1, 8'h4C, 32'h0,        0, 32'h0, 32'h0,        0, 0, 0, 0, 0));
    tbl.push_back(mk("cnt_zero",  1, 1, 8'h00, 32'h0,        0, 32'h0, 32'h0,        0, 0, 0, 1, 0));
    tbl.push_back(mk("load_b",    1, 1, 8'h4C, 32'h0,        0, 32'h0, 32'h0,        0, 0, 0, 0, 0));
    tbl.push_back(mk("cnt_65",    1, 1, 8'h41, 32'h0,        0, 32'h0, 32'h0,        0, 0, 0, 1, 0));
    tbl.push_back(mk("load_c",    1, 1, 8'h4C, 32'h0,        0, 32'h0, 32'h0,        0, 0, 0, 0, 0));
    tbl.push_back(mk("cnt_2",     1, 1, 8'h02, 32'h0,        0, 32'h0, 32'h0,        0, 0, 0, 0, 0));
    tbl.push_back(mk("w0_b0",     1, 1, 8'h78, 32'h0,        0, 32'h0, 32'h0,        0, 0, 0, 0, 0));
    tbl.push_back(mk("w0_b1",     1, 1, 8'h56, 32'h0,        0, 32'h0, 32'h0,        0, 0, 0, 0, 0));
    tbl.push_back(mk("w0_gap",    1, 0, 8'h00, 32'h0,        0, 32'h0, 32'h0,        0, 0, 0, 0, 0));
    tbl.push_back(mk("w0_b2",     1, 1, 8'h34, 32'h0,        0, 32'h0, 32'h0,        0, 0, 0, 0, 0));
    tbl.push_back(mk("w0_write",  1, 1, 8'h12, 32'h0,        1, 32'h0, 32'h12345678, 0, 0, 0, 0, 0));
    tbl.push_back(mk("w1_b0_wr",  1, 1, 8'h21, 32'h0,        0, 32'h0, 32'h0,        0, 0, 0, 0, 0));
    tbl.push_back(mk("w1_b1",     1, 1, 8'h43, 32'h0,        0, 32'h0, 32'h0,        0, 0, 0, 0, 0));
    tbl.push_back(mk("w1_b2",     1, 1, 8'h65, 32'h0,        0, 32'h0, 32'h0,        0, 0, 0, 0, 0));
    tbl.push_back(mk("w1_write",  1, 1, 8'h87, 32'h0,        1, 32'h4, 32'h87654321, 0, 0, 0, 0, 0));
    tbl.push_back(mk("load_done", 1, 0, 8'h00, 32'h0,        0, 32'h0, 32'h0,        0, 0, 1, 0, 1));
    tbl.push_back(mk("done_clr",  1, 0, 8'h00, 32'h0,        0, 32'h0, 32'h0,        0, 0, 0, 0, 1));
    tbl.push_back(mk("step",      1, 1, 8'h53, 32'h0,        0, 32'h0, 32'h0,        1, 0, 0, 0, 1));
    tbl.push_back(mk("step_end",  1, 0, 8'h00, 32'h0,        0, 32'h0, 32'h0,        0, 0, 0, 0, 1));
    tbl.push_back(mk("step_idle", 1, 0, 8'h00, 32'h0,        0, 32'h0, 32'h0,        0, 0, 0, 0, 1));

    foreach (tbl[i]) apply(tbl[i]);

    // Run, ignore a byte while running, then halt.
    apply(mk("run_go",     1, 1, 8'h43, 32'h0,        0, 32'h0, 32'h0, 1, 1, 0, 0, 1));
    apply(mk("run_rx53",   1, 1, 8'h53, 32'h0,        0, 32'h0, 32'h0, 1, 1, 0, 0, 1));
    apply(mk("run_hold",   1, 0, 8'h00, 32'h1234,     0, 32'h0, 32'h0, 1, 1, 0, 0, 1));
    apply(mk("run_halt",   1, 0, 8'h00, 32'hFFFFFFFF, 0, 32'h0, 32'h0, 0, 0, 0, 0, 1));
    apply(mk("halt_idle",  1, 0, 8'h00, 32'h0,        0, 32'h0, 32'h0, 0, 0, 0, 0, 1));

    // Halt on the very first RUN cycle.
    apply(mk("run2_go",    1, 1, 8'h43, 32'h0,        0, 32'h0, 32'h0, 1, 1, 0, 0, 1));
    apply(mk("run2_halt",  1, 0, 8'h00, 32'hFFFFFFFF, 0, 32'h0, 32'h0, 0, 0, 0, 0, 1));
    apply(mk("run2_idle",  1, 0, 8'h00, 32'h0,        0, 32'h0, 32'h0, 0, 0, 0, 0, 1));

    // Reset in the middle of a load, then a clean one-word load.
    apply(mk("ml_load",    1, 1, 8'h4C, 32'h0,        0, 32'h0, 32'h0, 0, 0, 0, 0, 1));
    apply(mk("ml_cnt3",    1, 1, 8'h03, 32'h0,        0, 32'h0, 32'h0, 0, 0, 0, 0, 0));
    apply(mk("ml_aa",      1, 1, 8'hAA, 32'h0,        0, 32'h0, 32'h0, 0, 0, 0, 0, 0));
    apply(mk("ml_bb",      1, 1, 8'hBB, 32'h0,        0, 32'h0, 32'h0, 0, 0, 0, 0, 0));
    apply(mk("ml_reset",   0, 1, 8'hCC, 32'h0,        0, 32'h0, 32'h0, 0, 0, 0, 0, 0));
    apply(mk("ml_post_dd", 1, 1, 8'hDD, 32'h0,        0, 32'h0, 32'h0, 0, 0, 0, 1, 0));
    apply(mk("rl_load",    1, 1, 8'h4C, 32'h0,        0, 32'h0, 32'h0, 0, 0, 0, 0, 0));
    apply(mk("rl_cnt1",    1, 1, 8'h01, 32'h0,        0, 32'h0, 32'h0, 0, 0, 0, 0, 0));
    apply(mk("rl_b0",      1, 1, 8'hEF, 32'h0,        0, 32'h0, 32'h0, 0, 0, 0, 0, 0));
    apply(mk("rl_b1",      1, 1, 8'hBE, 32'h0,        0, 32'h0, 32'h0, 0, 0, 0, 0, 0));
    apply(mk("rl_b2",      1, 1, 8'hAD, 32'h0,        0, 32'h0, 32'h0, 0, 0, 0, 0, 0));
    apply(mk("rl_write",   1, 1, 8'hDE, 32'h0,        1, 32'h0, 32'hDEADBEEF, 0, 0, 0, 0, 0));
    apply(mk("rl_done",    1, 0, 8'h00, 32'h0,        0, 32'h0, 32'h0, 0, 0, 1, 0, 1));
    apply(mk("rl_idle",    1, 0, 8'h00, 32'h0,        0, 32'h0, 32'h0, 0, 0, 0, 0, 1));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
